irq_capture_arbiter: RTL and testbench



---
 rtl/irq_capture_arbiter.sv | 204 ++++++++++++++++++++
 tb/tb_irq_capture_arbiter.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/irq_capture_arbiter.sv
// -----------------------------------------------------------------------------
// irq_capture_arbiter
//
// Interrupt capture front end for an external 8-to-3 priority encoder.
// Eight asynchronous request lines are synchronised and either edge-captured
// into a sticky pending register (EDGE_MODE=1) or mirrored as levels
// (EDGE_MODE=0). Unmasked pending bits are offered to the encoder. The code
// the encoder returns is sampled once and handed to the consumer on a
// valid/ack handshake.
//
// Parameters
//   SYNC_STAGES  synchroniser depth per source (2..4)
//   EDGE_MODE    1 = sticky rising-edge capture, 0 = level mode
//
// Optional feature
//   IRQ_OVERFLOW_EN  when defined, adds overflow_o[7:0]. A bit is set when a
//                    new edge arrives on a source whose pending bit is
//                    already set. It clears with the pending bit on ack.
//
// Ports
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   irq_in_i     raw asynchronous requests, bit 7 = highest priority
//   mask_i       1 = source masked (still latched, not offered)
//   enc_en_o     encoder enable, high for the single arbitration cycle
//   enc_req_o    request vector to the encoder (pending & ~mask)
//   enc_code_i   encoded index from the encoder, valid only while enc_en_o=1
//   irq_valid_o  interrupt id available to the consumer
//   irq_id_o     index of the interrupt being presented
//   irq_ack_i    consumer accepts irq_id_o, ignored while irq_valid_o=0
//   pending_o    raw pending register (status/debug)
//   overflow_o   repeated-edge flags (only with IRQ_OVERFLOW_EN)
// -----------------------------------------------------------------------------
// State  | Meaning
// IDLE   | nothing offered; waits for any unmasked pending bit
// ARB    | encoder enabled for one cycle; its code is sampled at the close
// VALID  | id held stable for the consumer until irq_ack_i
// -----------------------------------------------------------------------------
module irq_capture_arbiter #(
    parameter int SYNC_STAGES = 2,
    parameter int EDGE_MODE   = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] irq_in_i,
    input  logic [7:0] mask_i,
    output logic       enc_en_o,
    output logic [7:0] enc_req_o,
    input  logic [2:0] enc_code_i,
    output logic       irq_valid_o,
    output logic [2:0] irq_id_o,
    input  logic       irq_ack_i,
    output logic [7:0] pending_o
`ifdef IRQ_OVERFLOW_EN
    ,
    output logic [7:0] overflow_o
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARB   = 2'd1,
        VALID = 2'd2
    } state_t;

    // -------------------------------------------------------------------------
    // Input synchroniser plus one extra delay flop for edge detection
    // -------------------------------------------------------------------------
    logic [SYNC_STAGES-1:0][7:0] sync_q;
    logic [7:0]                  dly_q;
    logic [7:0]                  sync_last;
    logic [7:0]                  edge_det;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            dly_q  <= '0;
        end else begin
            sync_q[0] <= irq_in_i;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            dly_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign sync_last = sync_q[SYNC_STAGES-1];
    assign edge_det  = sync_last & ~dly_q;

    // -------------------------------------------------------------------------
    // Pending register
    // -------------------------------------------------------------------------
    state_t     state_q;
    logic       enc_en_q;
    logic       irq_valid_q;
    logic [2:0] irq_id_q;
    logic [7:0] pending_q;
    logic [7:0] pending_d;
    logic [7:0] enc_req;
    logic       ack_take;
    logic [7:0] clr_vec;

    assign enc_req  = pending_q & ~mask_i;
    assign ack_take = (state_q == VALID) && irq_ack_i;

    always_comb begin
        clr_vec = '0;
        if (ack_take && (EDGE_MODE != 0)) begin
            clr_vec = 8'h01 << irq_id_q;
        end
    end

    // The OR of the new edges after the clear lets a fresh edge win over
    // an ack of the same source, so no event is lost.
    always_comb begin
        if (EDGE_MODE != 0) begin
            pending_d = (pending_q & ~clr_vec) | edge_det;
        end else begin
            pending_d = sync_last;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

`ifdef IRQ_OVERFLOW_EN
    logic [7:0] overflow_q;
    logic [7:0] overflow_d;

    always_comb begin
        if (EDGE_MODE != 0) begin
            overflow_d = (overflow_q & ~clr_vec) | (edge_det & pending_q);
        end else begin
            overflow_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_q <= '0;
        end else begin
            overflow_q <= overflow_d;
        end
    end

    assign overflow_o = overflow_q;
`endif

    // -------------------------------------------------------------------------
    // Handshake FSM. enc_code_i is only looked at in ARB; elsewhere the
    // encoder output is undefined.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            enc_en_q    <= 1'b0;
            irq_valid_q <= 1'b0;
            irq_id_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (|enc_req) begin
                        state_q  <= ARB;
                        enc_en_q <= 1'b1;
                    end
                end
                ARB: begin
                    enc_en_q <= 1'b0;
                    // A mask change during ARB can leave nothing to present.
                    if (|enc_req) begin
                        irq_id_q    <= enc_code_i;
                        irq_valid_q <= 1'b1;
                        state_q     <= VALID;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                VALID: begin
                    if (irq_ack_i) begin
                        irq_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    enc_en_q    <= 1'b0;
                    irq_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign enc_en_o    = enc_en_q;
    assign enc_req_o   = enc_req;
    assign irq_valid_o = irq_valid_q;
    assign irq_id_o    = irq_id_q;
    assign pending_o   = pending_q;

endmodule

// File: tb/tb_irq_capture_arbiter.sv
// Bench for irq_capture_arbiter: one edge-mode and one level-mode instance,
// a behavioural reference model checked every cycle, and directed scenarios
// with hand-computed literal expectations.
module tb_irq_capture_arbiter;

    localparam int S = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] irq_in   [2];
    logic [7:0] mask     [2];
    logic       ack      [2];
    logic       enc_en   [2];
    logic [7:0] enc_req  [2];
    logic [2:0] enc_code [2];
    logic       valid    [2];
    logic [2:0] id       [2];
    logic [7:0] pend     [2];
`ifdef IRQ_OVERFLOW_EN
    logic [7:0] ovf      [2];
`endif

    int n_cmp = 0;
    int n_bad = 0;
    string pre [2] = '{"edge", "level"};

    function automatic logic [2:0] prio(input logic [7:0] v);
        logic [2:0] r;
        r = 3'd0;
        for (int i = 0; i < 8; i++) if (v[i]) r = 3'(i);
        return r;
    endfunction

    // Encoder model: correct code while enabled, deliberately wrong otherwise.
    assign enc_code[0] = enc_en[0] ? prio(enc_req[0]) : (prio(enc_req[0]) ^ 3'b101);
    assign enc_code[1] = enc_en[1] ? prio(enc_req[1]) : (prio(enc_req[1]) ^ 3'b101);

    irq_capture_arbiter #(.SYNC_STAGES(S), .EDGE_MODE(1)) u_edge (
        .clk(clk), .rst_n(rst_n),
        .irq_in_i(irq_in[0]), .mask_i(mask[0]),
        .enc_en_o(enc_en[0]), .enc_req_o(enc_req[0]), .enc_code_i(enc_code[0]),
        .irq_valid_o(valid[0]), .irq_id_o(id[0]), .irq_ack_i(ack[0]),
        .pending_o(pend[0])
`ifdef IRQ_OVERFLOW_EN
        , .overflow_o(ovf[0])
`endif
    );

    irq_capture_arbiter #(.SYNC_STAGES(S), .EDGE_MODE(0)) u_level (
        .clk(clk), .rst_n(rst_n),
        .irq_in_i(irq_in[1]), .mask_i(mask[1]),
        .enc_en_o(enc_en[1]), .enc_req_o(enc_req[1]), .enc_code_i(enc_code[1]),
        .irq_valid_o(valid[1]), .irq_id_o(id[1]), .irq_ack_i(ack[1]),
        .pending_o(pend[1])
`ifdef IRQ_OVERFLOW_EN
        , .overflow_o(ovf[1])
`endif
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Phase: 0 = nothing offered, 1 = encoder consulted, 2 = id presented.
    logic [7:0] m_pend [2];
    logic [7:0] m_ovf  [2];
    int         m_ph   [2];
    logic [2:0] m_id   [2];
    logic       m_val  [2];
    logic       m_en   [2];
    logic [7:0] m_hist [2][0:S+1];   // [0] = sample at latest edge

    task automatic model_reset(input int u);
        m_pend[u] = '0; m_ovf[u] = '0; m_ph[u] = 0;
        m_id[u] = '0; m_val[u] = 1'b0; m_en[u] = 1'b0;
        for (int j = 0; j <= S + 1; j++) m_hist[u][j] = '0;
    endtask

    task automatic model_step(input int u, input logic [7:0] smp,
                              input logic [7:0] mk, input logic ak, input bit edge_mode);
        logic [7:0] req, newe, clr;
        for (int j = S + 1; j > 0; j--) m_hist[u][j] = m_hist[u][j-1];
        m_hist[u][0] = smp;
        // An input level reaches the edge detector S edges after it is sampled.
        newe = m_hist[u][S] & ~m_hist[u][S+1];
        req  = m_pend[u] & ~mk;
        clr  = '0;
        if (m_ph[u] == 0) begin
            if (req != 0) begin m_ph[u] = 1; m_en[u] = 1'b1; end
        end else if (m_ph[u] == 1) begin
            m_en[u] = 1'b0;
            if (req != 0) begin m_id[u] = prio(req); m_val[u] = 1'b1; m_ph[u] = 2; end
            else m_ph[u] = 0;
        end else if (ak) begin
            if (edge_mode) clr = 8'h01 << m_id[u];
            m_val[u] = 1'b0;
            m_ph[u]  = 0;
        end
        m_ovf[u]  = edge_mode ? ((m_ovf[u] & ~clr) | (newe & m_pend[u])) : 8'h00;
        m_pend[u] = edge_mode ? ((m_pend[u] & ~clr) | newe) : m_hist[u][S];
    endtask

    logic [7:0] c_irq [2];
    logic [7:0] c_mask[2];
    logic       c_ack [2];

    initial begin
        model_reset(0);
        model_reset(1);
        forever begin
            @(posedge clk);
            for (int u = 0; u < 2; u++) begin
                c_irq[u] = irq_in[u]; c_mask[u] = mask[u]; c_ack[u] = ack[u];
            end
            #1;
            for (int u = 0; u < 2; u++) begin
                if (!rst_n) model_reset(u);
                else model_step(u, c_irq[u], c_mask[u], c_ack[u], (u == 0));
                chk({pre[u], ".pending"}, pend[u],    m_pend[u]);
                chk({pre[u], ".enc_en"},  enc_en[u],  m_en[u]);
                chk({pre[u], ".valid"},   valid[u],   m_val[u]);
                chk({pre[u], ".id"},      id[u],      m_id[u]);
                chk({pre[u], ".enc_req"}, enc_req[u], m_pend[u] & ~mask[u]);
`ifdef IRQ_OVERFLOW_EN
                chk({pre[u], ".overflow"}, ovf[u],    m_ovf[u]);
`endif
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_valid(input int u, input int budget);
        int k;
        k = 0;
        while (!valid[u] && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk({pre[u], ".valid_within_budget"}, valid[u], 1'b1);
    endtask

    task automatic pulse_ack(input int u);
        ack[u] = 1'b1;
        tick(1);
        ack[u] = 1'b0;
    endtask

    initial begin
        for (int u = 0; u < 2; u++) begin
            irq_in[u] = '0; mask[u] = '0; ack[u] = 1'b0;
        end
        rst_n = 1'b0;
        tick(3);
        chk("rst.valid", valid[0], 1'b0);
        chk("rst.pending", pend[0], 8'h00);
        chk("rst.enc_en", enc_en[0], 1'b0);
        chk("rst.id", id[0], 3'd0);
        rst_n = 1'b1;
        tick(2);

        // Single source on bit 3
        irq_in[0] = 8'h08;
        tick(3);
        chk("single.pending_e2", pend[0], 8'h08);
        chk("single.valid_early", valid[0], 1'b0);
        tick(1);
        chk("single.enc_en_pulse", enc_en[0], 1'b1);
        tick(1);
        chk("single.enc_en_drop", enc_en[0], 1'b0);
        chk("single.valid", valid[0], 1'b1);
        chk("single.id", id[0], 3'd3);
        pulse_ack(0);
        chk("single.pending_clr", pend[0], 8'h00);
        chk("single.valid_clr", valid[0], 1'b0);
        irq_in[0] = 8'h00;
        tick(4);

        // Priority and back-to-back
        irq_in[0] = 8'h81;
        wait_valid(0, 10);
        chk("prio.first_id", id[0], 3'd7);
        chk("prio.pending", pend[0], 8'h81);
        pulse_ack(0);
        chk("prio.gap1_valid", valid[0], 1'b0);
        chk("prio.gap1_pending", pend[0], 8'h01);
        tick(1);
        chk("prio.gap2_enc_en", enc_en[0], 1'b1);
        chk("prio.gap2_valid", valid[0], 1'b0);
        tick(1);
        chk("prio.second_valid", valid[0], 1'b1);
        chk("prio.second_id", id[0], 3'd0);
        pulse_ack(0);
        chk("prio.idle_pending", pend[0], 8'h00);
        chk("prio.idle_valid", valid[0], 1'b0);
        irq_in[0] = 8'h00;
        tick(4);

        // Mask applied during the arbitration cycle
        irq_in[0] = 8'h40;
        begin
            int k;
            k = 0;
            while (!enc_en[0] && k < 10) begin tick(1); k++; end
        end
        chk("arbmask.arb_seen", enc_en[0], 1'b1);
        mask[0] = 8'h40;
        tick(1);
        chk("arbmask.valid", valid[0], 1'b0);
        chk("arbmask.enc_en", enc_en[0], 1'b0);
        chk("arbmask.pending", pend[0], 8'h40);
        tick(3);
        chk("arbmask.still_idle", valid[0], 1'b0);
        mask[0] = 8'h00;
        wait_valid(0, 10);
        chk("arbmask.id", id[0], 3'd6);
        pulse_ack(0);
        irq_in[0] = 8'h00;
        tick(4);

        // Masking
        mask[0] = 8'h20;
        irq_in[0] = 8'h24;
        wait_valid(0, 10);
        chk("mask.id", id[0], 3'd2);
        pulse_ack(0);
        tick(4);
        chk("mask.pending", pend[0], 8'h20);
        chk("mask.no_valid", valid[0], 1'b0);
        ack[0] = 1'b1;
        tick(2);
        ack[0] = 1'b0;
        chk("mask.idle_ack_ignored", pend[0], 8'h20);
        mask[0] = 8'h00;
        wait_valid(0, 10);
        chk("mask.unmasked_id", id[0], 3'd5);

        // Asynchronous reset while presenting id 5
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst.valid", valid[0], 1'b0);
        chk("async_rst.pending", pend[0], 8'h00);
        chk("async_rst.enc_en", enc_en[0], 1'b0);
        chk("async_rst.id", id[0], 3'd0);
        irq_in[0] = 8'h00;
        tick(3);
        rst_n = 1'b1;
        tick(4);
        chk("async_rst.no_event", pend[0], 8'h00);

        // Set wins over clear on bit 4
        irq_in[0] = 8'h10;
        wait_valid(0, 10);
        chk("soc.id", id[0], 3'd4);
        irq_in[0] = 8'h00;
        tick(3);
        irq_in[0] = 8'h10;
        tick(2);
        chk("soc.still_valid", valid[0], 1'b1);
        pulse_ack(0);
        chk("soc.pending_kept", pend[0], 8'h10);
        chk("soc.valid_dropped", valid[0], 1'b0);
`ifdef IRQ_OVERFLOW_EN
        chk("soc.overflow_set", ovf[0], 8'h10);
`endif
        wait_valid(0, 10);
        chk("soc.re_id", id[0], 3'd4);
        pulse_ack(0);
        chk("soc.pending_final", pend[0], 8'h00);
`ifdef IRQ_OVERFLOW_EN
        chk("soc.overflow_clr", ovf[0], 8'h00);
`endif
        irq_in[0] = 8'h00;
        tick(4);

        // Level mode
        irq_in[1] = 8'h02;
        wait_valid(1, 10);
        chk("level.id", id[1], 3'd1);
        pulse_ack(1);
        chk("level.ack_closes", valid[1], 1'b0);
        chk("level.pending_kept", pend[1], 8'h02);
        wait_valid(1, 10);
        chk("level.re_id", id[1], 3'd1);
        pulse_ack(1);
        irq_in[1] = 8'h00;
        for (int k = 0; k < 8; k++) begin
            ack[1] = valid[1];
            tick(1);
        end
        ack[1] = 1'b0;
        tick(4);
        chk("level.dropped_valid", valid[1], 1'b0);
        chk("level.dropped_pending", pend[1], 8'h00);

        tick(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
